// File: rtl/tile_sched_pkg.sv
// Shared types and default widths for the tile skip scheduler and its stream stages.
package tile_sched_pkg;

    localparam int TSS_ADDR_W = 16;
    localparam int TSS_TILE_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } tss_state_e;

    typedef struct packed {
        logic [TSS_TILE_W-1:0] idx;
    } tile_t;

endpackage

// File: rtl/tile_sched_if.sv
// Bundle of layer control, mask ROM port and tile output stream of the scheduler.
// Stream rule: a tile transfers on a cycle with tile_valid && tile_ready; once raised,
// tile_valid and tile_idx stay stable until that cycle, and tile_ready alone has no effect.
interface tile_sched_if import tile_sched_pkg::*; #(
    parameter int ADDR_W = TSS_ADDR_W,
    parameter int TILE_W = TSS_TILE_W
) ();

    logic              start;
    logic [ADDR_W-1:0] mask_base;
    logic [TILE_W-1:0] num_tiles;
    logic [ADDR_W-1:0] mask_addr;
    logic              mask_bit;
    logic              tile_valid;
    logic              tile_ready;
    logic [TILE_W-1:0] tile_idx;
    logic              busy;
    logic              done;
    logic [TILE_W-1:0] active_count;
    logic [TILE_W-1:0] skipped_count;

    modport master (
        input  start, mask_base, num_tiles, mask_bit, tile_ready,
        output mask_addr, tile_valid, tile_idx, busy, done, active_count, skipped_count
    );

    modport slave (
        output start, mask_base, num_tiles, mask_bit, tile_ready,
        input  mask_addr, tile_valid, tile_idx, busy, done, active_count, skipped_count
    );

endinterface

// File: rtl/tile_mask_rom.sv
// Per-layer tile mask store: combinational 1-bit read, write port used to load contents.
module tile_mask_rom #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic              rdata_o
);

    logic mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/tile_out_reg.sv
// Single-entry valid/ready output register: load wins over clear, holds otherwise.
module tile_out_reg import tile_sched_pkg::*; #(
    parameter type data_t = tile_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  data_t data_i,
    input  logic  ready_i,
    output logic  valid_o,
    output data_t data_o,
    output logic  free_o
);

    logic  valid_q, valid_d;
    data_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/tile_skip_scheduler.sv
// Walks one layer's tile mask, streams out tiles whose bit is set and skips the rest
// at one per cycle, counting both kinds and pulsing done at the end of the layer.
module tile_skip_scheduler import tile_sched_pkg::*; #(
    parameter int ADDR_W = TSS_ADDR_W,
    parameter int TILE_W = TSS_TILE_W
) (
    input  logic        clk,
    input  logic        rst,
    tile_sched_if.master bus,
    output tss_state_e  dbg_state_o
);

    typedef logic [TILE_W-1:0] idx_t;

    tss_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    idx_t              num_q, num_d;
    idx_t              idx_q, idx_d;
    idx_t              act_q, act_d;
    idx_t              skip_q, skip_d;

    idx_t next_idx;
    logic advance;
    logic out_load;
    logic out_valid;
    logic out_free;
    idx_t out_idx;

    assign next_idx = idx_q + TILE_W'(1);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        addr_d   = addr_q;
        num_d    = num_q;
        idx_d    = idx_q;
        act_d    = act_q;
        skip_d   = skip_q;
        advance  = 1'b0;
        out_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d  = bus.mask_base;
                    addr_d  = bus.mask_base;
                    num_d   = bus.num_tiles;
                    idx_d   = '0;
                    act_d   = '0;
                    skip_d  = '0;
                    state_d = (bus.num_tiles == '0) ? FIN : SCAN;
                end
            end
            SCAN: begin
                if (!bus.mask_bit) begin
                    skip_d  = skip_q + TILE_W'(1);
                    advance = 1'b1;
                end else if (out_free) begin
                    out_load = 1'b1;
                    act_d    = act_q + TILE_W'(1);
                    advance  = 1'b1;
                end
                // End is tested before incrementing so a full-range layer never wraps idx.
                if (advance) begin
                    if (idx_q == num_q - TILE_W'(1)) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d  = next_idx;
                        addr_d = base_q + ADDR_W'(next_idx);
                    end
                end
            end
            DRAIN: begin
                if (!out_valid || bus.tile_ready) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            act_q   <= '0;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            skip_q  <= skip_d;
        end
    end

    tile_out_reg #(.data_t(idx_t)) u_out (
        .clk     (clk),
        .rst     (rst),
        .load_i  (out_load),
        .data_i  (idx_q),
        .ready_i (bus.tile_ready),
        .valid_o (out_valid),
        .data_o  (out_idx),
        .free_o  (out_free)
    );

    assign bus.mask_addr     = addr_q;
    assign bus.tile_valid    = out_valid;
    assign bus.tile_idx      = out_idx;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == FIN);
    assign bus.active_count  = act_q;
    assign bus.skipped_count = skip_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_tile_skip_scheduler.sv
// Bench for tile_skip_scheduler: layer-level model (expected tile list, address sweep,
// counts) checked every cycle, plus literal expectations for the directed layers.
module tb_tile_skip_scheduler;
    import tile_sched_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_sched_if bus();
    tss_state_e   dbg_state;

    logic        rom_we;
    logic [15:0] rom_waddr;
    logic        rom_wdata;
    logic        rom_rdata;

    tile_skip_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    tile_mask_rom #(.ADDR_W(16)) rom (
        .clk     (clk),
        .we_i    (rom_we),
        .waddr_i (rom_waddr),
        .wdata_i (rom_wdata),
        .raddr_i (bus.mask_addr),
        .rdata_o (rom_rdata)
    );

    assign bus.mask_bit = rom_rdata;

    // scoreboard state
    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [15:0] addr_seen[$];
    int          exp_act;
    int          cur_n;
    logic [15:0] cur_base;
    int          cyc = 0;
    int          first_hs, last_hs, hs_cnt;
    int          done_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_done  = 1'b0;
    logic [11:0] prev_idx   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // compare process
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", bus.tile_valid, 1);
                chk("hold_idx", bus.tile_idx, prev_idx);
            end
            if (bus.tile_valid && bus.tile_ready) begin
                hs_cnt++;
                if (hs_cnt == 1) first_hs = cyc;
                last_hs = cyc;
                got_q.push_back(bus.tile_idx);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_tile: got idx %0d, expected no more tiles", bus.tile_idx);
                end else begin
                    chk("tile_idx", bus.tile_idx, exp_q.pop_front());
                end
            end
            if (dbg_state == SCAN && (addr_seen.size() == 0 || addr_seen[$] != bus.mask_addr))
                addr_seen.push_back(bus.mask_addr);
            if (bus.done) begin
                done_cnt++;
                chk("done_pulse_len", prev_done, 0);
                chk("busy_at_done", bus.busy, 1);
                chk("active_count", bus.active_count, exp_act);
                chk("skipped_count", bus.skipped_count, cur_n - exp_act);
                chk("tiles_left", exp_q.size(), 0);
                chk("valid_at_done", bus.tile_valid, 0);
                chk("addr_sweep_len", addr_seen.size(), cur_n);
                for (int i = 0; i < addr_seen.size() && i < cur_n; i++)
                    chk("addr_sweep", addr_seen[i], 16'(cur_base + 16'(i)));
            end
            prev_valid = bus.tile_valid;
            prev_ready = bus.tile_ready;
            prev_idx   = bus.tile_idx;
            prev_done  = bus.done;
        end
    end

    // driver tasks
    task automatic load_mask(input logic [15:0] base, input int n, input logic [63:0] mask);
        for (int i = 0; i < n; i++) begin
            rom_we    = 1'b1;
            rom_waddr = 16'(base + 16'(i));
            rom_wdata = mask[i];
            @(posedge clk); #1;
        end
        rom_we = 1'b0;
    endtask

    task automatic start_layer(input logic [15:0] base, input int n, input logic [63:0] mask);
        exp_q.delete();
        got_q.delete();
        addr_seen.delete();
        exp_act = 0;
        hs_cnt  = 0;
        for (int i = 0; i < n; i++) begin
            if (mask[i]) begin
                exp_q.push_back(12'(i));
                exp_act++;
            end
        end
        cur_base      = base;
        cur_n         = n;
        bus.start     = 1'b1;
        bus.mask_base = base;
        bus.num_tiles = 12'(n);
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.mask_base = 16'hDEAD;
        bus.num_tiles = 12'd5;
    endtask

    task automatic run_layer(input logic [15:0] base, input int n, input logic [63:0] mask,
                             input int stall_lo, input int stall_hi, input int exp_lat,
                             input bit probe);
        int lat;
        lat = -1;
        start_layer(base, n, mask);
        for (int k = 0; k < 300; k++) begin
            bus.tile_ready = !(k >= stall_lo && k <= stall_hi);
            if (probe && k == 5) begin
                chk("stall_addr", bus.mask_addr, 16'h0103);
                chk("stall_valid", bus.tile_valid, 1);
                chk("stall_idx", bus.tile_idx, 2);
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk("done_seen", lat >= 0, 1);
        if (exp_lat >= 0 && lat >= 0) chk("done_latency", lat, exp_lat);
        @(posedge clk); #1;
        chk("idle_after_done", bus.busy, 0);
        bus.tile_ready = 1'b1;
    endtask

    task automatic check_t1_tiles();
        int t1_exp[4] = '{0, 2, 3, 6};
        chk("t1_tile_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            chk("t1_tile", got_q[i], t1_exp[i]);
        chk("t1_active", bus.active_count, 4);
        chk("t1_skipped", bus.skipped_count, 4);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst            = 1'b1;
        rom_we         = 1'b0;
        rom_waddr      = '0;
        rom_wdata      = 1'b0;
        bus.start      = 1'b0;
        bus.mask_base  = '0;
        bus.num_tiles  = '0;
        bus.tile_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", bus.mask_addr, 0);
        chk("rst_idx", bus.tile_idx, 0);
        chk("rst_valid", bus.tile_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_active", bus.active_count, 0);
        chk("rst_skipped", bus.skipped_count, 0);
        rst = 1'b0;
        bus.tile_ready = 1'b1;

        load_mask(16'h0100, 8, 64'h4D);
        load_mask(16'h0300, 16, 64'hFFFF);
        load_mask(16'hFFFE, 4, 64'hB);

        // layer 1: mixed mask, ready always high
        run_layer(16'h0100, 8, 64'h4D, 1000, 0, 9, 1'b0);
        check_t1_tiles();

        // layer 2: same mask, ready low for five cycles while tile 2 is pending
        run_layer(16'h0100, 8, 64'h4D, 3, 7, 14, 1'b1);
        check_t1_tiles();

        // layer 3: empty layer
        run_layer(16'h0000, 0, 64'h0, 1000, 0, 0, 1'b0);
        chk("empty_tiles", hs_cnt, 0);
        chk("empty_active", bus.active_count, 0);
        chk("empty_skipped", bus.skipped_count, 0);

        // layer 4: all ones, back-to-back
        run_layer(16'h0300, 16, 64'hFFFF, 1000, 0, 17, 1'b0);
        chk("b2b_count", hs_cnt, 16);
        chk("b2b_span", last_hs - first_hs, 15);

        // layer 5: address wrap
        run_layer(16'hFFFE, 4, 64'hB, 1000, 0, 5, 1'b0);
        chk("wrap_addr0", addr_seen[0], 16'hFFFE);
        chk("wrap_addr1", addr_seen[1], 16'hFFFF);
        chk("wrap_addr2", addr_seen[2], 16'h0000);
        chk("wrap_addr3", addr_seen[3], 16'h0001);
        chk("wrap_active", bus.active_count, 3);

        // layer 6: restart attempt mid-scan, then reset mid-layer
        start_layer(16'h0100, 8, 64'h4D);
        bus.tile_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.mask_base = 16'h0200;
        bus.num_tiles = 12'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ignored_start_addr", bus.mask_addr, 16'h0103);
        chk("ignored_start_busy", bus.busy, 1);
        chk("ignored_start_active", bus.active_count, 2);
        rst = 1'b1;
        d0  = done_cnt;
        @(posedge clk); #1;
        exp_q.delete();
        chk("midrst_addr", bus.mask_addr, 0);
        chk("midrst_valid", bus.tile_valid, 0);
        chk("midrst_idx", bus.tile_idx, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_active", bus.active_count, 0);
        chk("midrst_skipped", bus.skipped_count, 0);
        chk("midrst_state", dbg_state, IDLE);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("no_done_after_rst", done_cnt, d0);

        // layer 7: clean layer after reset
        run_layer(16'h0100, 8, 64'h4D, 1000, 0, 9, 1'b0);
        check_t1_tiles();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
